fp_mul_result_q: RTL

- Downstream stage of the combinational FP multiplier; captures its product word and one-hot class flags into a small FIFO.
- Presents the captured entries to the consumer over a valid/ready handshake.
- Keeps sticky exception status and saturating event counters for software and debug.
- Upstream logic drives in_valid whenever the multiplier operands are valid; it holds p and the class bits stable until accepted.

---
 rtl/fp_mul_result_q.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fp_mul_result_q.sv
// Result queue behind the combinational FP multiplier.
// Buffers product/class entries and tracks sticky status and event counts.
module fp_mul_result_q #(
  parameter int N_EXP = 11,
  parameter int N_MAN = 52,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int W  = N_EXP + N_MAN + 1,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_p,
  input  logic          in_nan,
  input  logic          in_inf,
  input  logic          in_zero,
  input  logic          in_dnorm,
  input  logic          in_norm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_p,
  output logic [4:0]    out_cls,
  input  logic          flag_clr,
  output logic [4:0]    sticky,
  output logic [CNT_W-1:0] cnt_nan,
  output logic [CNT_W-1:0] cnt_inf,
  output logic [CNT_W-1:0] cnt_zero,
  output logic [LW-1:0] level
);

  logic [W+4:0]    mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [LW-1:0]   level_q, level_d;
  logic [4:0]      sticky_q, sticky_d;
  logic [CNT_W-1:0] cn_q, cn_d;
  logic [CNT_W-1:0] ci_q, ci_d;
  logic [CNT_W-1:0] cz_q, cz_d;
  logic [4:0]      in_cls;
  logic [W+4:0]    head;
  logic            push, pop;

  function automatic logic [CNT_W-1:0] bump(
    input logic [CNT_W-1:0] c,
    input logic             hit
  );
    if (!hit || (&c)) return c;
    return c + CNT_W'(1);
  endfunction

  assign in_cls    = {in_nan, in_inf, in_zero, in_dnorm, in_norm};
  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_q];
  assign out_p     = out_valid ? head[W+4:5] : '0;
  assign out_cls   = out_valid ? head[4:0] : '0;
  assign level     = level_q;
  assign sticky    = sticky_q;
  assign cnt_nan   = cn_q;
  assign cnt_inf   = ci_q;
  assign cnt_zero  = cz_q;

  // Entry storage; contents are don't-care once the level says empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {in_p, in_cls};
  end

  // Pointer, level, sticky and counter next-state.
  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    level_d  = level_q;
    sticky_d = sticky_q;
    cn_d     = cn_q;
    ci_d     = ci_q;
    cz_d     = cz_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (flag_clr) begin
      sticky_d = push ? in_cls : '0;
      cn_d = (push && in_nan)  ? CNT_W'(1) : '0;
      ci_d = (push && in_inf)  ? CNT_W'(1) : '0;
      cz_d = (push && in_zero) ? CNT_W'(1) : '0;
    end else if (push) begin
      sticky_d = sticky_q | in_cls;
      cn_d = bump(cn_q, in_nan);
      ci_d = bump(ci_q, in_inf);
      cz_d = bump(cz_q, in_zero);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      sticky_q <= '0;
      cn_q     <= '0;
      ci_q     <= '0;
      cz_q     <= '0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      level_q  <= level_d;
      sticky_q <= sticky_d;
      cn_q     <= cn_d;
      ci_q     <= ci_d;
      cz_q     <= cz_d;
    end
  end

endmodule
